// File: rtl/nrisc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : nrisc_pkg
// Purpose : Shared definitions for the 8-bit NRISC processor: fetch-stage
//           state encoding, instruction width and default reset PC.
// Revision: 1.0 - initial release
// ============================================================================
package nrisc_pkg;

    localparam int         LARGURA_INSTR     = 8;
    localparam logic [7:0] PC_INICIAL_PADRAO = 8'h00;

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,  // one cycle after reset release
        PEDINDO  = 3'd1,  // memory request outstanding
        DESCARTE = 3'd2,  // request outstanding, its data will be dropped
        ENTREGA  = 3'd3,  // instruction presented on Instr
        PARADO   = 3'd4   // halted
    } estado_busca_t;

    // A memory read is in flight in both request-holding states.
    function automatic logic em_pedido(input estado_busca_t e);
        return (e == PEDINDO) || (e == DESCARTE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/contador_pc.sv
`default_nettype none
// ============================================================================
// Module  : contador_pc
// Purpose : Program counter register with asynchronous active-low reset,
//           increment enable and parallel load. Load wins over increment;
//           the increment wraps modulo 2^LARGURA.
// Ports   : clk      - clock
//           rst_n    - asynchronous active-low reset (loads VALOR_INICIAL)
//           i_inc    - increment by one
//           i_carga  - load i_valor
//           i_valor  - load value
//           o_pc     - current PC
// Revision: 1.0 - initial release
// ============================================================================
module contador_pc #(
    parameter int                 LARGURA       = 8,
    parameter logic [LARGURA-1:0] VALOR_INICIAL = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_inc,
    input  logic               i_carga,
    input  logic [LARGURA-1:0] i_valor,
    output logic [LARGURA-1:0] o_pc
);

    localparam logic [LARGURA-1:0] c_um = {{(LARGURA-1){1'b0}}, 1'b1};

    logic [LARGURA-1:0] r_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= VALOR_INICIAL;
        end else if (i_carga) begin
            r_pc <= i_valor;
        end else if (i_inc) begin
            r_pc <= r_pc + c_um;
        end
    end

    assign o_pc = r_pc;

endmodule
`default_nettype wire

// File: rtl/unidade_busca.sv
`default_nettype none
// ============================================================================
// Module  : unidade_busca
// Purpose : NRISC instruction fetch stage. Owns the PC, fetches one 8-bit
//           instruction per request over a ready-based memory handshake,
//           holds it on Instr until consumed, and handles taken branches,
//           halt and downstream stall.
// Ports   : Clock, ResetN           - clock, async active-low reset
//           Halt, Stall             - halt request, downstream not ready
//           Desvio, EnderecoDesvio  - taken branch pulse and target
//           MemReq, MemEnd          - memory read request and address
//           MemDado, MemPronto      - memory read data and response
//           Instr, InstrValida      - fetched instruction and valid flag
//           PcInstr                 - address Instr was fetched from
//           Parado                  - stage halted
// Revision: 1.0 - initial release
// ============================================================================
module unidade_busca
    import nrisc_pkg::*;
#(
    parameter int                     LARGURA_END = 8,
    parameter logic [LARGURA_END-1:0] PC_INICIAL  = PC_INICIAL_PADRAO
) (
    input  logic                     Clock,
    input  logic                     ResetN,
    input  logic                     Halt,
    input  logic                     Stall,
    input  logic                     Desvio,
    input  logic [LARGURA_END-1:0]   EnderecoDesvio,
    output logic                     MemReq,
    output logic [LARGURA_END-1:0]   MemEnd,
    input  logic [LARGURA_INSTR-1:0] MemDado,
    input  logic                     MemPronto,
    output logic [LARGURA_INSTR-1:0] Instr,
    output logic                     InstrValida,
    output logic [LARGURA_END-1:0]   PcInstr,
    output logic                     Parado
);

    estado_busca_t            r_estado;
    estado_busca_t            w_prox_estado;
    logic [LARGURA_END-1:0]   w_pc;
    logic                     w_captura;
    logic [LARGURA_END-1:0]   r_end_pedido;
    logic [LARGURA_INSTR-1:0] r_instr;
    logic [LARGURA_END-1:0]   r_pc_instr;

    // A response is kept only when no branch arrives on the same edge.
    assign w_captura = (r_estado == PEDINDO) && MemPronto && !Desvio;

    contador_pc #(
        .LARGURA       (LARGURA_END),
        .VALOR_INICIAL (PC_INICIAL)
    ) u_contador_pc (
        .clk     (Clock),
        .rst_n   (ResetN),
        .i_inc   (w_captura),
        .i_carga (Desvio),
        .i_valor (EnderecoDesvio),
        .o_pc    (w_pc)
    );

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            r_estado <= OCIOSO;
        end else begin
            r_estado <= w_prox_estado;
        end
    end

    always_comb begin
        w_prox_estado = r_estado;
        case (r_estado)
            OCIOSO: begin
                w_prox_estado = Halt ? PARADO : PEDINDO;
            end
            PEDINDO: begin
                if (MemPronto) begin
                    // Branch on the completing edge: data dropped, refetch.
                    if (Desvio) begin
                        w_prox_estado = Halt ? PARADO : PEDINDO;
                    end else begin
                        w_prox_estado = ENTREGA;
                    end
                end else if (Desvio) begin
                    w_prox_estado = DESCARTE;
                end
            end
            DESCARTE: begin
                if (MemPronto) begin
                    w_prox_estado = Halt ? PARADO : PEDINDO;
                end
            end
            ENTREGA: begin
                if (Desvio) begin
                    w_prox_estado = PEDINDO;
                end else if (!Stall) begin
                    w_prox_estado = Halt ? PARADO : PEDINDO;
                end
            end
            PARADO: begin
                if (!Halt) begin
                    w_prox_estado = PEDINDO;
                end
            end
            default: begin
                w_prox_estado = OCIOSO;
            end
        endcase
    end

    // r_end_pedido tracks the address of the request in flight, so that the
    // address stays stable in DESCARTE even though the PC already holds the
    // branch target.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            r_end_pedido <= PC_INICIAL;
            r_instr      <= '0;
            r_pc_instr   <= '0;
        end else begin
            if (r_estado == PEDINDO) begin
                r_end_pedido <= w_pc;
            end
            if (w_captura) begin
                r_instr    <= MemDado;
                r_pc_instr <= w_pc;
            end
        end
    end

    assign MemReq      = em_pedido(r_estado);
    assign MemEnd      = (r_estado == DESCARTE) ? r_end_pedido : w_pc;
    assign Instr       = r_instr;
    assign PcInstr     = r_pc_instr;
    assign InstrValida = (r_estado == ENTREGA);
    assign Parado      = (r_estado == PARADO);

endmodule
`default_nettype wire

// File: tb/tb_unidade_busca.sv
`default_nettype none
// ============================================================================
// Module  : tb_unidade_busca
// Purpose : Self-checking bench for unidade_busca with a behavioural
//           instruction memory of programmable latency and a transaction-level
//           model of the fetch stream (expected delivery addresses, memory
//           contents, handshake rules).
// Revision: 1.0 - initial release
// ============================================================================
module tb_unidade_busca;

    logic       Clock = 1'b0;
    logic       ResetN;
    logic       Halt;
    logic       Stall;
    logic       Desvio;
    logic [7:0] EnderecoDesvio;
    logic       MemReq;
    logic [7:0] MemEnd;
    logic [7:0] MemDado;
    logic       MemPronto;
    logic [7:0] Instr;
    logic       InstrValida;
    logic [7:0] PcInstr;
    logic       Parado;

    always #5 Clock = ~Clock;

    unidade_busca #(
        .LARGURA_END (8),
        .PC_INICIAL  (8'h00)
    ) dut (
        .Clock          (Clock),
        .ResetN         (ResetN),
        .Halt           (Halt),
        .Stall          (Stall),
        .Desvio         (Desvio),
        .EnderecoDesvio (EnderecoDesvio),
        .MemReq         (MemReq),
        .MemEnd         (MemEnd),
        .MemDado        (MemDado),
        .MemPronto      (MemPronto),
        .Instr          (Instr),
        .InstrValida    (InstrValida),
        .PcInstr        (PcInstr),
        .Parado         (Parado)
    );

    // Instruction memory: contents mem[a] = a ^ 8'hA5, answers after 'lat'
    // cycles of an outstanding request (lat = 0 answers in the same cycle).
    logic [7:0] mem [256];
    logic [7:0] r_wait = 8'd0;
    int         lat = 0;

    assign MemDado   = mem[MemEnd];
    assign MemPronto = MemReq && (int'(r_wait) >= lat);

    always @(posedge Clock) begin
        if (!MemReq || MemPronto) r_wait <= 8'd0;
        else                      r_wait <= r_wait + 8'd1;
    end

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    logic [7:0] exp_pc[$];
    logic [7:0] req_log[$];
    int         req_cyc[$];
    logic [7:0] dlv_pc[$];
    logic [7:0] dlv_instr[$];
    int         dlv_cyc[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare process, sampling mid-low-phase.
    logic       p_req = 1'b0, p_pronto = 1'b0, p_val = 1'b0;
    logic [7:0] p_end = 8'h00;

    always begin
        @(negedge Clock);
        #1;
        cyc++;
        if (!ResetN) begin
            chk("rst_MemReq", MemReq, 0);
            chk("rst_MemEnd", MemEnd, 8'h00);
            chk("rst_Instr", Instr, 0);
            chk("rst_PcInstr", PcInstr, 0);
            chk("rst_InstrValida", InstrValida, 0);
            chk("rst_Parado", Parado, 0);
            p_req = 1'b0; p_pronto = 1'b0; p_val = 1'b0;
        end else begin
            if (InstrValida) chk("instr_vs_mem", Instr, mem[PcInstr]);
            chk("valid_req_exclusive", InstrValida && MemReq, 0);
            if (Parado) chk("parado_quiet", MemReq || InstrValida, 0);
            if (p_req && !p_pronto) begin
                chk("req_not_withdrawn", MemReq, 1);
                chk("memend_stable", MemEnd, p_end);
            end
            if (MemReq && (!p_req || p_pronto)) begin
                req_log.push_back(MemEnd);
                req_cyc.push_back(cyc);
            end
            if (InstrValida && !p_val) begin
                dlv_pc.push_back(PcInstr);
                dlv_instr.push_back(Instr);
                dlv_cyc.push_back(cyc);
                if (exp_pc.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_delivery: got pc %0h expected none", PcInstr);
                end else begin
                    chk("delivery_pc", PcInstr, exp_pc.pop_front());
                end
            end
            p_req = MemReq; p_pronto = MemPronto; p_end = MemEnd; p_val = InstrValida;
        end
    end

    task automatic step();
        @(negedge Clock);
        #2;
    endtask

    task automatic wait_dlv(input int k, input int budget, input string nm);
        int n = 0;
        while (dlv_pc.size() < k && n < budget) begin step(); n++; end
        chk({nm, "_dlv_timeout"}, dlv_pc.size() >= k, 1);
    endtask

    task automatic wait_req(input int k, input int budget, input string nm);
        int n = 0;
        while (req_log.size() < k && n < budget) begin step(); n++; end
        chk({nm, "_req_timeout"}, req_log.size() >= k, 1);
    endtask

    task automatic clear_logs();
        req_log.delete(); req_cyc.delete();
        dlv_pc.delete(); dlv_instr.delete(); dlv_cyc.delete();
    endtask

    task automatic do_reset();
        ResetN = 1'b0; Halt = 1'b0; Stall = 1'b0; Desvio = 1'b0;
        step();
        exp_pc.delete();
        clear_logs();
        step();
    endtask

    task automatic end_test(input string nm);
        chk({nm, "_all_delivered"}, exp_pc.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
        ResetN = 1'b0; Halt = 1'b0; Stall = 1'b0; Desvio = 1'b0;
        EnderecoDesvio = 8'h00;
        step(); step();

        // Reset state
        chk("t0_MemReq", MemReq, 0);
        chk("t0_MemEnd", MemEnd, 8'h00);
        chk("t0_InstrValida", InstrValida, 0);
        chk("t0_Parado", Parado, 0);

        // Sequential fetch, same-cycle memory
        lat = 0;
        exp_pc.push_back(8'h00); exp_pc.push_back(8'h01); exp_pc.push_back(8'h02);
        ResetN = 1'b1;
        wait_dlv(3, 30, "t1");
        chk("t1_instr0", dlv_instr[0], 8'hA5);
        chk("t1_instr1", dlv_instr[1], 8'hA4);
        chk("t1_instr2", dlv_instr[2], 8'hA7);
        chk("t1_end0", req_log[0], 8'h00);
        chk("t1_end1", req_log[1], 8'h01);
        chk("t1_end2", req_log[2], 8'h02);
        chk("t1_latency", dlv_cyc[0] - req_cyc[0], 1);
        chk("t1_rate01", dlv_cyc[1] - dlv_cyc[0], 2);
        chk("t1_rate12", dlv_cyc[2] - dlv_cyc[1], 2);
        end_test("t1");

        // Stall holds the instruction
        do_reset();
        lat = 0; Stall = 1'b1;
        exp_pc.push_back(8'h00); exp_pc.push_back(8'h01);
        ResetN = 1'b1;
        wait_dlv(1, 20, "t2");
        for (int i = 0; i < 3; i++) begin
            chk("t2_hold_instr", Instr, 8'hA5);
            chk("t2_hold_valid", InstrValida, 1);
            chk("t2_hold_noreq", MemReq, 0);
            if (i < 2) step();
        end
        Stall = 1'b0;
        step();
        chk("t2_refetch_req", MemReq, 1);
        chk("t2_refetch_end", MemEnd, 8'h01);
        wait_dlv(2, 20, "t2");
        end_test("t2");

        // Branch while a slow request is outstanding
        do_reset();
        lat = 3;
        exp_pc.push_back(8'h40); exp_pc.push_back(8'h41);
        ResetN = 1'b1;
        wait_req(1, 20, "t3");
        step();
        Desvio = 1'b1; EnderecoDesvio = 8'h40;
        step();
        Desvio = 1'b0;
        wait_dlv(2, 40, "t3");
        chk("t3_end0", req_log[0], 8'h00);
        chk("t3_end1", req_log[1], 8'h40);
        chk("t3_end2", req_log[2], 8'h41);
        chk("t3_instr0", dlv_instr[0], 8'hE5);
        end_test("t3");

        // Halt during an outstanding request
        do_reset();
        lat = 3;
        exp_pc.push_back(8'h00); exp_pc.push_back(8'h01);
        ResetN = 1'b1;
        wait_req(1, 20, "t4");
        step();
        Halt = 1'b1;
        begin
            int n = 0;
            while (!Parado && n < 20) begin step(); n++; end
        end
        chk("t4_parado", Parado, 1);
        chk("t4_parado_noreq", MemReq, 0);
        chk("t4_delivered_one", dlv_pc.size(), 1);
        chk("t4_latency", dlv_cyc[0] - req_cyc[0], 4);
        step(); step();
        chk("t4_still_parado", Parado, 1);
        chk("t4_still_noreq", MemReq, 0);
        Halt = 1'b0;
        wait_req(2, 20, "t4");
        chk("t4_resume_end", req_log[1], 8'h01);
        wait_dlv(2, 20, "t4");
        end_test("t4");

        // PC wrap at 8'hFF
        do_reset();
        lat = 0;
        exp_pc.push_back(8'hFF); exp_pc.push_back(8'h00);
        Desvio = 1'b1; EnderecoDesvio = 8'hFF;
        ResetN = 1'b1;
        step();
        Desvio = 1'b0;
        wait_dlv(2, 20, "t5");
        chk("t5_end0", req_log[0], 8'hFF);
        chk("t5_end1", req_log[1], 8'h00);
        chk("t5_instr0", dlv_instr[0], 8'h5A);
        chk("t5_instr1", dlv_instr[1], 8'hA5);
        end_test("t5");

        // Asynchronous reset mid-request
        do_reset();
        lat = 3;
        exp_pc.push_back(8'h00);
        ResetN = 1'b1;
        wait_req(1, 20, "t6");
        step();
        chk("t6_pre_req", MemReq, 1);
        ResetN = 1'b0;
        #1;
        chk("t6_async_MemReq", MemReq, 0);
        chk("t6_async_MemEnd", MemEnd, 8'h00);
        chk("t6_async_Instr", Instr, 0);
        chk("t6_async_PcInstr", PcInstr, 0);
        chk("t6_async_InstrValida", InstrValida, 0);
        chk("t6_async_Parado", Parado, 0);
        clear_logs();
        step();
        ResetN = 1'b1;
        wait_dlv(1, 30, "t6");
        chk("t6_first_end", req_log[0], 8'h00);
        end_test("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
